// File: rtl/alu_mult_seq_pkg.sv
// Shared types and constants for the Booth multiply sequencer and its step logic.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] ALU_OP_ADD = 5'b00000;
    localparam logic [4:0] ALU_OP_SUB = 5'b00001;
    localparam int         CNT_W      = 6;

endpackage

// File: rtl/alu_mult_seq_if.sv
// Bundle of the request/result handshake and the shared-ALU connection of the multiply sequencer.
interface alu_mult_seq_if;

    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        busy;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB, alu_result, alu_overflow,
        output alu_operandA, alu_operandB, alu_opcode, busy,
               data_result, data_exception, data_resultRDY
    );

    modport master (
        output ctrl_MULT, data_operandA, data_operandB, alu_result, alu_overflow,
        input  alu_operandA, alu_operandB, alu_opcode, busy,
               data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/alu_mult_seq_booth_step.sv
// One radix-2 Booth iteration: picks the ALU operation from {LO[0],QM1} and forms the
// arithmetically shifted next product register from the ALU result.
module booth_step
    import mult_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] m,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        qm1_next
);

    logic sign_s;

    // Booth recoding of the current multiplier bit pair and the 65-bit arithmetic shift.
    always_comb begin
        alu_operandA = hi;
        case (sel)
            2'b01: begin
                alu_opcode   = ALU_OP_ADD;
                alu_operandB = m;
            end
            2'b10: begin
                alu_opcode   = ALU_OP_SUB;
                alu_operandB = m;
            end
            default: begin
                alu_opcode   = ALU_OP_ADD;
                alu_operandB = 32'd0;
            end
        endcase
        // The 33-bit sign survives a wrap of the 32-bit ALU, needed when M = -2^31.
        sign_s   = alu_result[31] ^ alu_overflow;
        hi_next  = {sign_s, alu_result[31:1]};
        lo_next  = {alu_result[0], lo[31:1]};
        qm1_next = lo[0];
    end

endmodule

// File: rtl/alu_mult_seq.sv
// Iterative signed 32x32 Booth multiplier that borrows the execute-stage ALU for each add/sub.
// Optional build macro MULT_ZERO_SKIP_EN: a start with a zero operand completes on the next cycle.
module alu_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input logic           clock,
    input logic           reset_n,
    alu_mult_seq_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, result_q, result_d;
    logic             qm1_q, qm1_d, exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]       step_op_s;
    logic [31:0]      step_a_s, step_b_s, hi_nx_s, lo_nx_s;
    logic             qm1_nx_s;

    booth_step u_step (
        .sel          ({lo_q[0], qm1_q}),
        .hi           (hi_q),
        .lo           (lo_q),
        .m            (m_q),
        .alu_result   (bus.alu_result),
        .alu_overflow (bus.alu_overflow),
        .alu_opcode   (step_op_s),
        .alu_operandA (step_a_s),
        .alu_operandB (step_b_s),
        .hi_next      (hi_nx_s),
        .lo_next      (lo_nx_s),
        .qm1_next     (qm1_nx_s)
    );

    // ALU drive: the shared ALU only sees a non-zero request while a multiply is running.
    always_comb begin
        if (state_q == RUN) begin
            bus.alu_opcode   = step_op_s;
            bus.alu_operandA = step_a_s;
            bus.alu_operandB = step_b_s;
        end else begin
            bus.alu_opcode   = ALU_OP_ADD;
            bus.alu_operandA = 32'd0;
            bus.alu_operandB = 32'd0;
        end
    end

    // Next-state, product register, counter and result computation.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.ctrl_MULT) begin
                    hi_d    = {WIDTH{1'b0}};
                    lo_d    = bus.data_operandB;
                    qm1_d   = 1'b0;
                    m_d     = bus.data_operandA;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
`ifdef MULT_ZERO_SKIP_EN
                    if ((bus.data_operandA == 32'd0) || (bus.data_operandB == 32'd0)) begin
                        state_d  = DONE;
                        rdy_d    = 1'b1;
                        result_d = {WIDTH{1'b0}};
                        exc_d    = 1'b0;
                    end else begin
                        state_d  = RUN;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                hi_d  = hi_nx_s;
                lo_d  = lo_nx_s;
                qm1_d = qm1_nx_s;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d  = DONE;
                    rdy_d    = 1'b1;
                    result_d = lo_nx_s;
                    exc_d    = (hi_nx_s != {WIDTH{lo_nx_s[WIDTH-1]}});
                end else begin
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    // State and output registers; reset discards any partial product.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            qm1_q    <= 1'b0;
            m_q      <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            result_q <= {WIDTH{1'b0}};
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a behavioural ALU and a product scoreboard.
module tb_alu_mult_seq;
    import mult_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;

    alu_mult_seq_if bus ();

    alu_mult_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] alu_r;
    logic        alu_v;
    always_comb begin
        if (bus.alu_opcode == ALU_OP_SUB) begin
            alu_r = bus.alu_operandA - bus.alu_operandB;
            alu_v = (bus.alu_operandA[31] != bus.alu_operandB[31]) && (alu_r[31] != bus.alu_operandA[31]);
        end else begin
            alu_r = bus.alu_operandA + bus.alu_operandB;
            alu_v = (bus.alu_operandA[31] == bus.alu_operandB[31]) && (alu_r[31] != bus.alu_operandA[31]);
        end
    end
    assign bus.alu_result   = alu_r;
    assign bus.alu_overflow = alu_v;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          start;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge; the start is sampled on the following posedge.
    task automatic start_mult(input logic [31:0] a, input logic [31:0] b, input bit track);
        exp_t        e;
        longint      p;
        logic [31:0] lo32;
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        p      = longint'($signed(a)) * longint'($signed(b));
        lo32   = p[31:0];
        e.res  = lo32;
        e.exc  = (p != longint'($signed(lo32)));
        e.start = cyc + 1;
        e.lat  = 32;
`ifdef MULT_ZERO_SKIP_EN
        if ((a == 32'd0) || (b == 32'd0)) e.lat = 0;
`endif
        if (track) sb.push_back(e);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
    endtask

    task automatic wait_rdy(input string tag);
        exp_t e;
        bit   seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.data_resultRDY === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check({tag, "_rdy_seen"}, 64'(seen), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                check({tag, "_result"}, 64'(bus.data_result), 64'(e.res));
                check({tag, "_exc"}, 64'(bus.data_exception), 64'(e.exc));
                check({tag, "_latency"}, 64'(cyc - e.start), 64'(e.lat));
            end
        end
    endtask

    initial begin
        int extra;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("rst_result", 64'(bus.data_result), 64'd0);
        check("rst_exc", 64'(bus.data_exception), 64'd0);
        check("rst_op", 64'(bus.alu_opcode), 64'(ALU_OP_ADD));
        check("rst_opa", 64'(bus.alu_operandA), 64'd0);
        check("rst_opb", 64'(bus.alu_operandB), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 3 x -7: first step subtracts M since Q ends in binary 1
        start_mult(32'd3, 32'hFFFF_FFF9, 1'b1);
        check("run_busy", 64'(bus.busy), 64'd1);
        check("run_op", 64'(bus.alu_opcode), 64'(ALU_OP_SUB));
        check("run_opa", 64'(bus.alu_operandA), 64'd0);
        check("run_opb", 64'(bus.alu_operandB), 64'd3);
        wait_rdy("m3xm7");
        @(negedge clock);
        check("rdy_pulse", 64'(bus.data_resultRDY), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_opb", 64'(bus.alu_operandB), 64'd0);
        check("hold_result", 64'(bus.data_result), 64'h0000_0000_FFFF_FFEB);

        start_mult(32'h7FFF_FFFF, 32'd2, 1'b1);
        wait_rdy("maxx2");
        @(negedge clock);
        start_mult(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_rdy("minxm1");
        @(negedge clock);
        start_mult(32'h8000_0000, 32'd1, 1'b1);
        wait_rdy("minx1");
        @(negedge clock);

        // Start pulse during RUN must be ignored
        start_mult(32'd5, 32'd6, 1'b1);
        repeat (9) @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'h0000_1111;
        bus.data_operandB = 32'h0000_2222;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        wait_rdy("ignore");
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) extra++;
        end
        check("no_extra_rdy", 64'(extra), 64'd0);

        // Reset in the middle of a multiply
        start_mult(32'h0000_1234, 32'h0000_5678, 1'b0);
        repeat (14) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("mid_rst_result", 64'(bus.data_result), 64'd0);
        check("mid_rst_exc", 64'(bus.data_exception), 64'd0);
        check("mid_rst_opa", 64'(bus.alu_operandA), 64'd0);
        check("mid_rst_opb", 64'(bus.alu_operandB), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        start_mult(32'h0001_2345, 32'hFFFF_FCDF, 1'b1);
        wait_rdy("restart");

        // Back-to-back: new start in the DONE cycle
        @(negedge clock);
        start_mult(32'hFFFF_FF9C, 32'd77, 1'b1);
        wait_rdy("b2b_first");
        start_mult(32'h0000_DEAD, 32'h0000_BEEF, 1'b1);
        check("b2b_rdy_low", 64'(bus.data_resultRDY), 64'd0);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        wait_rdy("b2b_second");

        @(negedge clock);
        start_mult(32'd0, 32'd5, 1'b1);
        wait_rdy("zero");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
